// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory responder.
//   * RV32I load/store size codes (funct3)
//   * FSM state enum: IDLE / ACCESS / RESP
//   * captured request record {we, funct3, addr, wdata}
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align -- combinational byte-lane steering for one access.
// Optional feature: DMEM_MISALIGN_CHECK_EN (flags misaligned half/word).
// Ports:
//   we         in   1 = store, 0 = load
//   funct3     in   RV32I size/sign code
//   addr_lo    in   byte offset within the word (addr[1:0])
//   wdata      in   right-justified store data
//   rdata_word in   raw 32-bit word read from the array
//   byte_en    out  per-lane write enables (all 0 on error)
//   wdata_rep  out  store data replicated across lanes
//   rdata_ext  out  load data shifted down and extended (0 on error)
//   size_err   out  illegal funct3 for this direction, or misaligned
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        size_err
);

  logic misalign;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) ||
                    ((funct3 == F3_W) && (addr_lo != 2'b00));
`else
  // Low offset bits are simply ignored: halves use addr[1], words lane 0 up.
  assign misalign = 1'b0;
`endif

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata_word[7:0];
    case (addr_lo)
      2'd1:    sel_byte = rdata_word[15:8];
      2'd2:    sel_byte = rdata_word[23:16];
      2'd3:    sel_byte = rdata_word[31:24];
      default: sel_byte = rdata_word[7:0];
    endcase
    sel_half = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
  end

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = 32'd0;
    size_err  = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{sel_byte[7]}}, sel_byte}
                                     : {24'd0, sel_byte};
        size_err  = we && (funct3 == F3_BU);  // no unsigned stores
      end
      F3_H, F3_HU: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = (funct3 == F3_H) ? {{16{sel_half[15]}}, sel_half}
                                     : {16'd0, sel_half};
        size_err  = we && (funct3 == F3_HU);
      end
      F3_W: begin
        byte_en   = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata_word;
      end
      default: size_err = 1'b1;
    endcase
    if (size_err || misalign) begin
      size_err  = 1'b1;
      byte_en   = 4'b0000;
      rdata_ext = 32'd0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder -- single-outstanding data-memory responder with a fixed
// access latency. Optional feature: DMEM_MISALIGN_CHECK_EN (see lane align).
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we, req_funct3    store flag and RV32I size code
//   req_addr, req_wdata   byte address and right-justified store data
//   rsp_valid/rsp_ready   response handshake (valid only in RESP)
//   rsp_rdata, rsp_err    extended load data (0 on store/error), fault flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  req_t        req_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  logic [31:0] rd_word;
  logic [3:0]  byte_en;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;
  logic        size_err;

  // The array is read at the accept edge straight from req_addr, so the word
  // is registered and stable for the whole ACCESS phase (any LATENCY >= 1).
  logic          rd_fire;
  logic          rd_in_range;
  logic [AW-1:0] rd_idx;
  logic          range_err;
  logic [AW-1:0] wr_idx;
  logic          last_access;
  logic          access_err;
  logic          wr_fire;

  assign rd_fire     = (state_reg == IDLE) && req_valid;
  assign rd_in_range = req_addr[31:2] < 30'(DEPTH_WORDS);
  assign rd_idx      = rd_in_range ? req_addr[AW+1:2] : '0;

  assign range_err   = req_reg.addr[31:2] >= 30'(DEPTH_WORDS);
  assign wr_idx      = range_err ? '0 : req_reg.addr[AW+1:2];
  assign last_access = (state_reg == ACCESS) && (cnt_reg == 4'd0);
  assign access_err  = size_err || range_err;
  // state_reg is cleared asynchronously, so a store in flight when reset
  // rises can never reach this enable.
  assign wr_fire     = last_access && req_reg.we && !access_err && !reset;

  dmem_lane_align u_align (
    .we         (req_reg.we),
    .funct3     (req_reg.funct3),
    .addr_lo    (req_reg.addr[1:0]),
    .wdata      (req_reg.wdata),
    .rdata_word (rd_word),
    .byte_en    (byte_en),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (rdata_ext),
    .size_err   (size_err)
  );

  // One byte-wide array per lane; contents are never reset.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] rd_byte_reg;

    always_ff @(posedge clk) begin
      if (wr_fire && byte_en[gi]) begin
        lane_mem[wr_idx] <= wdata_rep[8*gi +: 8];
      end
      if (rd_fire) begin
        rd_byte_reg <= lane_mem[rd_idx];
      end
    end

    assign rd_word[8*gi +: 8] = rd_byte_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      req_reg       <= '0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            req_reg   <= '{we: req_we, funct3: req_funct3,
                           addr: req_addr, wdata: req_wdata};
            cnt_reg   <= 4'(LATENCY - 1);
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_reg == 4'd0) begin
            rsp_err_reg   <= access_err;
            rsp_rdata_reg <= (req_reg.we || access_err) ? 32'd0 : rdata_ext;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- directed test of dmem_responder (DEPTH_WORDS=256,
// LATENCY=2) with hand-computed expected values. Honours
// DMEM_MISALIGN_CHECK_EN when the design is built with it.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete request/response. Inputs change 1 ns after a rising edge;
  // outputs are sampled there too. 'hold' keeps rsp_ready low that many
  // extra cycles while the response must stay put.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int hold);
    int guard;
    int edges;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;                       // accept edge = edge 1
    // Scramble the request lines; they must be ignored from here on.
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFC;
    req_wdata  = 32'hA5A5_A5A5;
    edges = 1;
    while (!rsp_valid && edges < 64) begin
      @(posedge clk); #1; edges++;
    end
    check({tag, " valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " lat"}, 32'(edges), 32'(LAT + 1));
    check({tag, " rdata"}, rsp_rdata, exp_rdata);
    check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " hold rdata"}, rsp_rdata, exp_rdata);
      check({tag, " hold ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " done"}, 32'(rsp_valid), 32'd0);
    $display("xact %-10s we=%0d f3=%03b addr=0x%08h wdata=0x%08h -> exp rdata=0x%08h err=%0d",
             tag, we, f3, addr, wdata, exp_rdata, exp_err);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b0;
    #1;
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst valid", 32'(rsp_valid), 32'd0);
    check("rst rdata", rsp_rdata, 32'd0);
    check("rst err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic store/load round trip.
    xact("sw64", 1'b1, F3_W, 32'h64, 32'h0000_0019, 32'd0, 1'b0, 0);
    xact("lw64", 1'b0, F3_W, 32'h64, 32'd0, 32'h0000_0019, 1'b0, 0);

    // Sign/zero extension.
    xact("sw10", 1'b1, F3_W,  32'h10, 32'h80FF_7F01, 32'd0, 1'b0, 0);
    xact("lb13", 1'b0, F3_B,  32'h13, 32'd0, 32'hFFFF_FF80, 1'b0, 0);
    xact("lbu13", 1'b0, F3_BU, 32'h13, 32'd0, 32'h0000_0080, 1'b0, 0);
    xact("lh12", 1'b0, F3_H,  32'h12, 32'd0, 32'hFFFF_80FF, 1'b0, 0);
    xact("lhu10", 1'b0, F3_HU, 32'h10, 32'd0, 32'h0000_7F01, 1'b0, 0);

    // Partial stores with replicated data.
    xact("sw20", 1'b1, F3_W, 32'h20, 32'h1122_3344, 32'd0, 1'b0, 0);
    xact("sb21", 1'b1, F3_B, 32'h21, 32'h0000_00AB, 32'd0, 1'b0, 0);
    xact("lw20a", 1'b0, F3_W, 32'h20, 32'd0, 32'h1122_AB44, 1'b0, 0);
    xact("sh22", 1'b1, F3_H, 32'h22, 32'h0000_BEEF, 32'd0, 1'b0, 0);
    xact("lw20b", 1'b0, F3_W, 32'h20, 32'd0, 32'hBEEF_AB44, 1'b0, 0);
    xact("lb21", 1'b0, F3_B, 32'h21, 32'd0, 32'hFFFF_FFAB, 1'b0, 0);
    xact("lhu22", 1'b0, F3_HU, 32'h22, 32'd0, 32'h0000_BEEF, 1'b0, 0);

    // Misaligned word access.
`ifdef DMEM_MISALIGN_CHECK_EN
    xact("lw22", 1'b0, F3_W, 32'h22, 32'd0, 32'd0, 1'b1, 0);
    xact("sw22", 1'b1, F3_W, 32'h22, 32'h5555_5555, 32'd0, 1'b1, 0);
    xact("lw20c", 1'b0, F3_W, 32'h20, 32'd0, 32'hBEEF_AB44, 1'b0, 0);
`else
    xact("lw22", 1'b0, F3_W, 32'h22, 32'd0, 32'hBEEF_AB44, 1'b0, 0);
`endif

    // Out-of-range load held in RESP for 5 cycles.
    xact("lwoor", 1'b0, F3_W, 32'(4 * DEPTH), 32'd0, 32'd0, 1'b1, 5);

    // Out-of-range store must not alias onto any word (e.g. word 0).
    xact("sw0", 1'b1, F3_W, 32'h0, 32'h0102_0304, 32'd0, 1'b0, 0);
    xact("swoor", 1'b1, F3_W, 32'(4 * DEPTH), 32'hCAFE_F00D, 32'd0, 1'b1, 0);
    xact("lw0", 1'b0, F3_W, 32'h0, 32'd0, 32'h0102_0304, 1'b0, 0);

    // Illegal funct3 codes.
    xact("ld011", 1'b0, 3'b011, 32'h20, 32'd0, 32'd0, 1'b1, 0);
    xact("st100", 1'b1, F3_BU, 32'h20, 32'h0000_0077, 32'd0, 1'b1, 0);
    xact("st110", 1'b1, 3'b110, 32'h20, 32'h7777_7777, 32'd0, 1'b1, 0);
    xact("lw20d", 1'b0, F3_W, 32'h20, 32'd0, 32'hBEEF_AB44, 1'b0, 0);

    // Reset during ACCESS of a store.
    xact("sw30", 1'b1, F3_W, 32'h30, 32'h1234_5678, 32'd0, 1'b0, 0);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h30;
    req_wdata  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    check("rst mid access", 32'(req_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("rst async ready", 32'(req_ready), 32'd1);
    check("rst async valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst after valid", 32'(rsp_valid), 32'd0);
    check("rst after rdata", rsp_rdata, 32'd0);
    $display("xact %-10s reset asserted during ACCESS of sw 0x30=0xDEADBEEF", "rstsw30");
    xact("lw30", 1'b0, F3_W, 32'h30, 32'd0, 32'h1234_5678, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
